// File: rtl/memoria_fifo_ctrl.sv
// memoria_fifo_ctrl: FIFO controller in front of a 16x4 single-port synchronous RAM.
// Accepts push/pop requests, drives RAM addr/din/wea (registered), and captures
// RAM dout into a registered pop output two edges after a pop is accepted.
// Pop has priority over push; one RAM access per cycle.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   push, push_data     enqueue request and data
//   push_ready          combinational: push would be accepted this cycle
//   pop                 dequeue request
//   pop_data, pop_valid registered dequeued word and one-cycle strobe
//   full, empty, count  occupancy status (count = 0..2**ADDR_W)
//   err                 sticky overflow/underflow attempt flag
//   mem_addr, mem_din,
//   mem_wea             registered RAM controls
//   mem_dout            RAM read data (valid one cycle after addr is sampled)
module memoria_fifo_ctrl #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              push_ready,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_wea,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int unsigned   DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [ADDR_W:0]   count_q,    count_d;
    logic [DATA_W-1:0] pop_data_q, pop_data_d;
    logic              pop_valid_q, pop_valid_d;
    logic              err_q,      err_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q,  mem_din_d;
    logic              mem_wea_q,  mem_wea_d;
    logic              rd_s1_q,    rd_s1_d;
    logic              rd_s2_q,    rd_s2_d;

    logic pop_acc;
    logic push_acc;

    // Status derived from the registered occupancy
    assign full       = (count_q == FULL_CNT);
    assign empty      = (count_q == '0);
    assign pop_acc    = pop && !empty;
    assign push_acc   = push && !full && !pop_acc;
    assign push_ready = !full && !(pop && !empty);

    assign count     = count_q;
    assign pop_data  = pop_data_q;
    assign pop_valid = pop_valid_q;
    assign err       = err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign mem_wea   = mem_wea_q;

    // Next-state: pointer/occupancy update, RAM command, read pipeline
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        mem_wea_d   = 1'b0;
        err_d       = err_q | (push & full) | (pop & empty);
        // rd_s1: RAM samples addr next edge; rd_s2: mem_dout valid now
        rd_s1_d     = pop_acc;
        rd_s2_d     = rd_s1_q;
        pop_valid_d = rd_s2_q;
        pop_data_d  = rd_s2_q ? mem_dout : pop_data_q;

        if (pop_acc) begin
            mem_addr_d = rd_ptr_q;
            rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
            count_d    = count_q - (ADDR_W + 1)'(1);
        end else if (push_acc) begin
            mem_addr_d = wr_ptr_q;
            mem_din_d  = push_data;
            mem_wea_d  = 1'b1;
            wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
            count_d    = count_q + (ADDR_W + 1)'(1);
        end
    end

    // State registers; reset also discards in-flight reads
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            mem_wea_q   <= 1'b0;
            rd_s1_q     <= 1'b0;
            rd_s2_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            mem_wea_q   <= mem_wea_d;
            rd_s1_q     <= rd_s1_d;
            rd_s2_q     <= rd_s2_d;
        end
    end

endmodule
